seq_detector_arbiter: RTL and testbench
=======================================

Name: seq_detector_arbiter

Overview:
Shares one bit-serial "11011" pattern-detector datapath between two byte-stream requesters.
- Arbitrates between channel 0 and channel 1 round-robin.
- Accepts one byte per grant and shifts it MSB-first through the detector FSM.
- Saves and restores each channel's 3-bit detector state, so patterns spanning byte boundaries within a channel are still detected.
- Sits between the byte sources and the match-count / interrupt logic.

Parameters:
- BYTE_W, 8: bits per accepted word; shift length per grant.
- CNT_W, 8: width of each per-channel saturating hit counter.

Ports:
- clk, input, 1: single clock, rising edge.
- async_reset_n, input, 1: asynchronous active-low reset.
- req_valid, input, 2: per-channel byte valid.
- req_data0, input, BYTE_W: channel 0 byte.
- req_data1, input, BYTE_W: channel 1 byte.
- req_ready, output, 2: one-hot accept pulse; a handshake occurs when valid and ready are both high.
- ser_bit, output, 1: bit currently presented to the detector.
- ser_ch, output, 1: channel owning ser_bit.
- ser_active, output, 1: ser_bit is valid this cycle.
- hit, output, 1: pattern completed this cycle (registered, one cycle after the bit).
- hit_ch, output, 1: channel of hit.
- hit_count0, output, CNT_W: channel 0 saturating hit count.
- hit_count1, output, CNT_W: channel 1 saturating hit count.
- busy, output, 1: controller not in IDLE.

Behaviour:
- Reset values: all outputs 0; both channel contexts = S0; last_grant = 1, so channel 0 wins first.
- Controller states:
  - IDLE: if any req_valid, grant per round-robin and pulse req_ready[g] combinationally in the same cycle; latch the byte; go to SHIFT with bit_idx = BYTE_W-1.
  - SHIFT: ser_active = 1; ser_bit = shreg[bit_idx]; ser_ch = g.
- Detector step, once per SHIFT cycle, on ctx[g]:
  - Encodings: S0=000, S1=001, S11=010, S110=011, S1101=100.
  - S0: 1→S1, 0→S0.
  - S1: 1→S11, 0→S0.
  - S11: 1→S11, 0→S110.
  - S110: 1→S1101, 0→S0.
  - S1101: 1→S11 with hit, 0→S0.
  - Any other encoding → S0.
- Hit reporting: registered hit/hit_ch assert the cycle after the bit.
- Hit counters: the counter for the hit's channel increments and holds at 2^CNT_W-1.
- End of byte:
  - On bit_idx==0 with any req_valid: re-arbitrate in that same cycle, pulse req_ready, and continue SHIFT with no bubble.
  - Otherwise go to IDLE.
  - Sustained throughput: one byte per BYTE_W cycles.
- Round-robin: when both channels are valid, grant !last_grant. last_grant updates on every handshake.
- Valid deasserting mid-shift has no effect; the byte was already captured.
- The idle channel's context is never modified.
- Reset asserted mid-shift: the byte is lost, both contexts and counters clear, no hit is emitted.
- req_ready is never high outside a grant cycle and is never high for both channels at once.

Optional Feature:
SEQDET_ARB_FIXED_PRIO_EN
- Defined: channel 0 always wins when both channels are valid; last_grant is unused.
- Undefined: round-robin as above.

Decomposition:
- Package seq_detector_pkg holds:
  - detector state encodings (S0..S1101) and the 3-bit state typedef;
  - controller state encodings (IDLE, SHIFT).
- One natural sub-module, seq_detector_step: combinational step (state, bit) → (next_state, hit). The arbiter instantiates it once and muxes ctx[g] in and out.

Test Plan:
- Single byte: ch0 sends 0xDB → req_ready[0] pulses once; 8 serial bits; hit on bits 5 and 8; hit_count0 = 2; hit_count1 = 0.
- Cross-byte context: ch0 0x0D, then ch1 0xFF, then ch0 0x80 → no hits for ch1; ch0 hits on the first bit of 0x80; hit_count0 = 1.
- Fairness: both channels hold valid with 0x00 for 6 bytes → grants alternate 0,1,0,1,0,1; there is no idle cycle between bytes; busy stays 1.
- Saturation: ch1 sends 0xDB 130 times → hit_count1 = 255 and holds.
- Mid-shift reset: assert async_reset_n low at bit 3 of 0xDB → all outputs 0 immediately; next byte 0xDB after release again yields exactly 2 hits.
- With SEQDET_ARB_FIXED_PRIO_EN: both channels continuously valid → only channel 0 is granted.

Source files
------------

// File: rtl/seq_detector_pkg.sv
// Shared definitions for the two-channel "11011" serial pattern detector.
//   - det_state_t : 3-bit detector context, encodings S0..S1101
//   - ctrl_state_t: arbiter/serialiser controller states (IDLE, SHIFT)
package seq_detector_pkg;

  typedef logic [2:0] det_state_t;

  localparam det_state_t S0    = 3'b000;
  localparam det_state_t S1    = 3'b001;
  localparam det_state_t S11   = 3'b010;
  localparam det_state_t S110  = 3'b011;
  localparam det_state_t S1101 = 3'b100;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ctrl_state_t;

endpackage

// File: rtl/seq_detector_step.sv
// One combinational step of the overlapping "11011" detector.
// Ports:
//   state      : current detector context
//   bit_in     : serial bit being consumed
//   next_state : context after consuming bit_in
//   hit        : bit_in completed the pattern
module seq_detector_step
  import seq_detector_pkg::*;
(
  input  det_state_t state,
  input  logic       bit_in,
  output det_state_t next_state,
  output logic       hit
);

  always_comb begin
    next_state = S0;
    hit        = 1'b0;
    case (state)
      S0:    next_state = bit_in ? S1   : S0;
      S1:    next_state = bit_in ? S11  : S0;
      S11:   next_state = bit_in ? S11  : S110;
      S110:  next_state = bit_in ? S1101 : S0;
      S1101: begin
        // Overlap: the trailing "11" of a match starts the next one.
        next_state = bit_in ? S11 : S0;
        hit        = bit_in;
      end
      default: next_state = S0;  // unused encodings recover to S0
    endcase
  end

endmodule

// File: rtl/seq_detector_arbiter.sv
// Shares one bit-serial "11011" detector between two byte-stream channels.
// Each grant accepts one byte, which is shifted MSB-first through the
// detector using that channel's saved context, so patterns spanning byte
// boundaries within a channel are found. Per-channel saturating hit counts.
// Compile option: SEQDET_ARB_FIXED_PRIO_EN -> channel 0 always wins ties;
// otherwise ties are broken round-robin.
// Ports:
//   clk, async_reset_n       : clock, asynchronous active-low reset
//   req_valid[1:0]           : per-channel byte valid
//   req_data0/1              : channel bytes
//   req_ready[1:0]           : one-hot accept pulse (combinational)
//   ser_bit/ser_ch/ser_active: bit presented to the detector, its channel
//   hit/hit_ch               : registered match pulse and its channel
//   hit_count0/1             : saturating per-channel match counts
//   busy                     : controller not idle
module seq_detector_arbiter
  import seq_detector_pkg::*;
#(
  parameter int BYTE_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              async_reset_n,
  input  logic [1:0]        req_valid,
  input  logic [BYTE_W-1:0] req_data0,
  input  logic [BYTE_W-1:0] req_data1,
  output logic [1:0]        req_ready,
  output logic              ser_bit,
  output logic              ser_ch,
  output logic              ser_active,
  output logic              hit,
  output logic              hit_ch,
  output logic [CNT_W-1:0]  hit_count0,
  output logic [CNT_W-1:0]  hit_count1,
  output logic              busy
);

  localparam int IDX_W = (BYTE_W > 1) ? $clog2(BYTE_W) : 1;

  ctrl_state_t       state, state_nxt;
  logic [IDX_W-1:0]  bit_idx;
  logic [BYTE_W-1:0] shreg;
  logic              g;
  det_state_t        ctx0, ctx1, ctx_cur, ctx_nxt;
  logic              step_hit;
  logic              shifting, last_bit, any_valid, pick, grant;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  assign any_valid = |req_valid;
  assign shifting  = (state == SHIFT);
  assign last_bit  = shifting && (bit_idx == '0);
  assign busy      = (state != IDLE);

`ifdef SEQDET_ARB_FIXED_PRIO_EN
  assign pick = ~req_valid[0];
`else
  logic last_grant;
  assign pick = (&req_valid) ? ~last_grant : req_valid[1];
`endif

  // Grant while idle, or on the final bit of a byte so the next byte
  // follows with no bubble. Held off while reset is asserted.
  assign grant     = async_reset_n && any_valid && (!shifting || last_bit);
  assign req_ready = grant ? (pick ? 2'b10 : 2'b01) : 2'b00;

  always_comb begin
    state_nxt  = state;
    ser_active = 1'b0;
    ser_bit    = 1'b0;
    ser_ch     = 1'b0;
    case (state)
      IDLE: if (any_valid) state_nxt = SHIFT;
      SHIFT: begin
        ser_active = 1'b1;
        ser_bit    = shreg[bit_idx];
        ser_ch     = g;
        if ((bit_idx == '0) && !any_valid) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign ctx_cur = g ? ctx1 : ctx0;

  seq_detector_step u_step (
    .state      (ctx_cur),
    .bit_in     (ser_bit),
    .next_state (ctx_nxt),
    .hit        (step_hit)
  );

  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) state <= IDLE;
    else                state <= state_nxt;
  end

  // Control: grant bookkeeping, detector contexts, hit reporting
  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) begin
      bit_idx    <= '0;
      g          <= 1'b0;
`ifndef SEQDET_ARB_FIXED_PRIO_EN
      last_grant <= 1'b1;
`endif
      ctx0       <= S0;
      ctx1       <= S0;
      hit        <= 1'b0;
      hit_ch     <= 1'b0;
      hit_count0 <= '0;
      hit_count1 <= '0;
    end else begin
      if (grant) begin
        g          <= pick;
        bit_idx    <= IDX_W'(BYTE_W - 1);
`ifndef SEQDET_ARB_FIXED_PRIO_EN
        last_grant <= pick;
`endif
      end else if (shifting && (bit_idx != '0)) begin
        bit_idx <= bit_idx - 1'b1;
      end

      if (shifting) begin
        if (g) ctx1 <= ctx_nxt;
        else   ctx0 <= ctx_nxt;
      end

      hit    <= shifting && step_hit;
      hit_ch <= shifting && step_hit && g;
      if (shifting && step_hit) begin
        if (g) hit_count1 <= sat_inc(hit_count1);
        else   hit_count0 <= sat_inc(hit_count0);
      end
    end
  end

  // Data: byte capture
  always_ff @(posedge clk) begin
    if (grant) shreg <= pick ? req_data1 : req_data0;
  end

endmodule

// File: tb/tb_seq_detector_arbiter.sv
module tb_seq_detector_arbiter;
  import seq_detector_pkg::*;

  logic       clk = 1'b0;
  logic       async_reset_n = 1'b0;
  logic [1:0] req_valid = 2'b00;
  logic [7:0] req_data0 = 8'h00;
  logic [7:0] req_data1 = 8'h00;
  logic [1:0] req_ready;
  logic       ser_bit, ser_ch, ser_active, hit, hit_ch, busy;
  logic [7:0] hit_count0, hit_count1;

  int checks   = 0;
  int failures = 0;

  seq_detector_arbiter #(.BYTE_W(8), .CNT_W(8)) dut (
    .clk           (clk),
    .async_reset_n (async_reset_n),
    .req_valid     (req_valid),
    .req_data0     (req_data0),
    .req_data1     (req_data1),
    .req_ready     (req_ready),
    .ser_bit       (ser_bit),
    .ser_ch        (ser_ch),
    .ser_active    (ser_active),
    .hit           (hit),
    .hit_ch        (hit_ch),
    .hit_count0    (hit_count0),
    .hit_count1    (hit_count1),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ready"},  {30'd0, req_ready}, 32'd0);
    chk({tag, "_active"}, {31'd0, ser_active}, 32'd0);
    chk({tag, "_bit"},    {31'd0, ser_bit}, 32'd0);
    chk({tag, "_serch"},  {31'd0, ser_ch}, 32'd0);
    chk({tag, "_hit"},    {31'd0, hit}, 32'd0);
    chk({tag, "_hitch"},  {31'd0, hit_ch}, 32'd0);
    chk({tag, "_cnt0"},   {24'd0, hit_count0}, 32'd0);
    chk({tag, "_cnt1"},   {24'd0, hit_count1}, 32'd0);
    chk({tag, "_busy"},   {31'd0, busy}, 32'd0);
  endtask

  // Sends one byte from an idle controller; hmask[i] = hit expected after bit i.
  task automatic send_byte(input logic ch, input logic [7:0] d,
                           input logic [7:0] hmask, input logic detail);
    if (ch) begin req_valid = 2'b10; req_data1 = d; end
    else    begin req_valid = 2'b01; req_data0 = d; end
    #1;
    if (detail) chk("grant_ready", {30'd0, req_ready}, ch ? 32'd2 : 32'd1);
    step();
    req_valid = 2'b00;
    for (int i = 7; i >= 0; i--) begin
      if (detail) begin
        chk("ser_active", {31'd0, ser_active}, 32'd1);
        chk("ser_bit",    {31'd0, ser_bit}, {31'd0, d[i]});
        chk("ser_ch",     {31'd0, ser_ch}, {31'd0, ch});
        chk("no_ready",   {30'd0, req_ready}, 32'd0);
      end
      step();
      if (detail) begin
        chk("hit", {31'd0, hit}, {31'd0, hmask[i]});
        if (hmask[i]) chk("hit_ch", {31'd0, hit_ch}, {31'd0, ch});
      end
    end
    if (detail) chk("idle_after", {31'd0, busy}, 32'd0);
  endtask

  task automatic do_reset();
    req_valid = 2'b00;
    async_reset_n = 1'b0;
    #1;
    check_all_zero("reset");
    step();
    async_reset_n = 1'b1;
    step();
  endtask

  initial begin
    logic [1:0] exp_grant;

    // Single byte 0xDB on ch0: 11011011 -> hits after bits 5 and 8
    do_reset();
    send_byte(1'b0, 8'hDB, 8'b0000_1001, 1'b1);
    chk("t1_cnt0", {24'd0, hit_count0}, 32'd2);
    chk("t1_cnt1", {24'd0, hit_count1}, 32'd0);

    // Cross-byte context: ch0 ends 0x0D in S1101, ch1 unaffected,
    // ch0's 0x80 hits on its first bit
    do_reset();
    send_byte(1'b0, 8'h0D, 8'b0000_0000, 1'b1);
    send_byte(1'b1, 8'hFF, 8'b0000_0000, 1'b1);
    send_byte(1'b0, 8'h80, 8'b1000_0000, 1'b1);
    chk("t2_cnt0", {24'd0, hit_count0}, 32'd1);
    chk("t2_cnt1", {24'd0, hit_count1}, 32'd0);

    // Fairness: both valid for 6 back-to-back bytes
    do_reset();
    req_data0 = 8'h00;
    req_data1 = 8'h00;
    req_valid = 2'b11;
    #1;
    for (int k = 0; k < 6; k++) begin
`ifdef SEQDET_ARB_FIXED_PRIO_EN
      exp_grant = 2'b01;
`else
      exp_grant = (k % 2 == 1) ? 2'b10 : 2'b01;
`endif
      chk("fair_grant", {30'd0, req_ready}, {30'd0, exp_grant});
      step();
      if (k == 5) req_valid = 2'b00;
      for (int j = 0; j < 8; j++) begin
        chk("fair_busy", {31'd0, busy}, 32'd1);
        chk("fair_serch", {31'd0, ser_ch}, {31'd0, exp_grant[1]});
        if (j < 7) begin
          chk("fair_noready", {30'd0, req_ready}, 32'd0);
          step();
        end
      end
    end
    chk("fair_last_ready", {30'd0, req_ready}, 32'd0);
    step();
    chk("fair_idle", {31'd0, busy}, 32'd0);

    // Saturation: 130 x 0xDB on ch1 = 260 hits, counter pins at 255
    do_reset();
    for (int n = 0; n < 127; n++) send_byte(1'b1, 8'hDB, 8'b0000_1001, 1'b0);
    chk("sat_254", {24'd0, hit_count1}, 32'd254);
    send_byte(1'b1, 8'hDB, 8'b0000_1001, 1'b1);
    chk("sat_255", {24'd0, hit_count1}, 32'd255);
    send_byte(1'b1, 8'hDB, 8'b0000_1001, 1'b0);
    send_byte(1'b1, 8'hDB, 8'b0000_1001, 1'b1);
    chk("sat_hold", {24'd0, hit_count1}, 32'd255);
    chk("sat_cnt0", {24'd0, hit_count0}, 32'd0);

    // Mid-shift reset: reset during the fourth bit of 0xDB
    do_reset();
    send_byte(1'b0, 8'hDB, 8'b0000_1001, 1'b0);
    chk("mr_pre_cnt0", {24'd0, hit_count0}, 32'd2);
    req_valid = 2'b01;
    req_data0 = 8'hDB;
    step();
    req_valid = 2'b00;
    for (int i = 0; i < 3; i++) step();
    chk("mr_active_before", {31'd0, ser_active}, 32'd1);
    async_reset_n = 1'b0;
    #1;
    check_all_zero("midreset");
    step();
    check_all_zero("midreset_hold");
    async_reset_n = 1'b1;
    step();
    send_byte(1'b0, 8'hDB, 8'b0000_1001, 1'b1);
    chk("mr_post_cnt0", {24'd0, hit_count0}, 32'd2);
    chk("mr_post_cnt1", {24'd0, hit_count1}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
